// File: rtl/main_control_fsm_pkg.sv
// -----------------------------------------------------------------------------
// main_control_fsm_pkg
// Shared definitions for the multicycle MIPS main controller: opcode values,
// state encodings, the ALU-op / ALU-B / PC-source select codes and the
// control-word struct that the output decoder hands to the top level.
// The ALU-op codes are the ones the ALU-control decoder expects.
// -----------------------------------------------------------------------------
package main_control_fsm_pkg;

  localparam int STATE_BITS = 4;

  // Opcodes, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  // BNEEX keeps its encoding in every build; without the BNE option it is
  // unreachable and handled like any other illegal encoding.
  typedef enum logic [STATE_BITS-1:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11,
    BNEEX   = 4'd12
  } state_e;

  // 2'b10 is reserved and never driven.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b11
  } aluop_e;

  typedef enum logic [1:0] {
    SRCB_REGB    = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alusrcb_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pcsrc_e;

  typedef struct packed {
    logic     iord;
    logic     memwrite;
    logic     irwrite;
    logic     regdst;
    logic     memtoreg;
    logic     regwrite;
    logic     alusrca;
    alusrcb_e alusrcb;
    aluop_e   aluop;
    pcsrc_e   pcsrc;
    logic     pcwrite;
    logic     branch;
    logic     bne;
  } ctrl_word_t;

endpackage

// File: rtl/main_control_fsm_ctrl_output_decoder.sv
// -----------------------------------------------------------------------------
// main_control_fsm_ctrl_output_decoder
// Combinational state -> control word decode for the main controller.
// Moore decode except that the FETCH and MEMWR write enables follow
// i_mem_ready. While i_rst_n is low every enable is forced to 0 so that no
// write escapes during reset even though FETCH decodes ready-dependent
// enables. Unrecognised state encodings decode as FETCH.
// Optional feature: define MAIN_CTRL_BNE_EN to decode the BNEEX state;
// otherwise o_ctrl.bne is always 0.
// Ports:
//   i_state      current FSM state
//   i_mem_ready  memory access completes this cycle
//   i_rst_n      asynchronous active-low reset (enable gating only)
//   o_ctrl       datapath control word
// -----------------------------------------------------------------------------
module main_control_fsm_ctrl_output_decoder
  import main_control_fsm_pkg::*;
(
  input  state_e     i_state,
  input  logic       i_mem_ready,
  input  logic       i_rst_n,
  output ctrl_word_t o_ctrl
);

  ctrl_word_t cw;

  // NOTE: every field gets a default before the case so no path leaves a
  // field unassigned, which would otherwise infer a latch.
  always_comb begin
    cw = '0;
    case (i_state)
      FETCH: begin
        cw.alusrcb  = SRCB_FOUR;
        cw.aluop    = ALUOP_ADD;
        cw.irwrite  = i_mem_ready;
        cw.pcwrite  = i_mem_ready;
      end
      DECODE: begin
        cw.alusrcb  = SRCB_IMM_SH2;
        cw.aluop    = ALUOP_ADD;
      end
      MEMADR: begin
        cw.alusrca  = 1'b1;
        cw.alusrcb  = SRCB_IMM;
        cw.aluop    = ALUOP_ADD;
      end
      MEMRD: begin
        cw.iord     = 1'b1;
      end
      MEMWB: begin
        cw.memtoreg = 1'b1;
        cw.regwrite = 1'b1;
      end
      MEMWR: begin
        // Strobe only on the completing cycle: exactly one write per SW.
        cw.iord     = 1'b1;
        cw.memwrite = i_mem_ready;
      end
      RTYPEEX: begin
        cw.alusrca  = 1'b1;
        cw.alusrcb  = SRCB_REGB;
        cw.aluop    = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        cw.regdst   = 1'b1;
        cw.regwrite = 1'b1;
      end
      BEQEX: begin
        cw.alusrca  = 1'b1;
        cw.alusrcb  = SRCB_REGB;
        cw.aluop    = ALUOP_SUB;
        cw.pcsrc    = PCSRC_ALUOUT;
        cw.branch   = 1'b1;
      end
      ADDIEX: begin
        cw.alusrca  = 1'b1;
        cw.alusrcb  = SRCB_IMM;
        cw.aluop    = ALUOP_ADD;
      end
      ADDIWB: begin
        cw.regwrite = 1'b1;
      end
      JEX: begin
        cw.pcsrc    = PCSRC_JUMP;
        cw.pcwrite  = 1'b1;
      end
`ifdef MAIN_CTRL_BNE_EN
      BNEEX: begin
        cw.alusrca  = 1'b1;
        cw.alusrcb  = SRCB_REGB;
        cw.aluop    = ALUOP_SUB;
        cw.pcsrc    = PCSRC_ALUOUT;
        cw.bne      = 1'b1;
      end
`endif
      default: begin
        // Illegal encodings look like FETCH for the one cycle they exist.
        cw.alusrcb  = SRCB_FOUR;
        cw.aluop    = ALUOP_ADD;
        cw.irwrite  = i_mem_ready;
        cw.pcwrite  = i_mem_ready;
      end
    endcase
  end

  always_comb begin
    o_ctrl = cw;
    if (!i_rst_n) begin
      o_ctrl.memwrite = 1'b0;
      o_ctrl.irwrite  = 1'b0;
      o_ctrl.regwrite = 1'b0;
      o_ctrl.pcwrite  = 1'b0;
      o_ctrl.branch   = 1'b0;
      o_ctrl.bne      = 1'b0;
    end
  end

endmodule

// File: rtl/main_control_fsm.sv
// -----------------------------------------------------------------------------
// main_control_fsm
// Multicycle MIPS main controller. Moore FSM sequencing fetch / decode /
// execute / writeback from the instruction opcode; drives PC, IR, regfile,
// memory and ALU mux controls plus the 2-bit ALU-op code consumed by the
// ALU-control decoder. Holds the state register and next-state logic; the
// control word comes from main_control_fsm_ctrl_output_decoder.
// Optional feature: define MAIN_CTRL_BNE_EN to support BNE (opcode 000101)
// through a BNEEX state driving o_bne. Without it o_bne stays 0 and 000101
// is reported as illegal.
// Ports:
//   i_clk, i_rst_n      clock (rising edge), asynchronous active-low reset
//   i_opcode            instr[31:26] from the instruction register
//   i_mem_ready         memory access done this cycle (FETCH/MEMRD/MEMWR)
//   o_iord .. o_bne     datapath enables and mux selects
//   o_illegal           one-cycle pulse in DECODE on an unsupported opcode
//   o_state             current state for debug/verification
// -----------------------------------------------------------------------------
module main_control_fsm
  import main_control_fsm_pkg::*;
#(
  parameter int STATE_W = STATE_BITS
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [5:0]         i_opcode,
  input  logic               i_mem_ready,
  output logic               o_iord,
  output logic               o_memwrite,
  output logic               o_irwrite,
  output logic               o_regdst,
  output logic               o_memtoreg,
  output logic               o_regwrite,
  output logic               o_alusrca,
  output logic [1:0]         o_alusrcb,
  output logic [1:0]         o_aluop,
  output logic [1:0]         o_pcsrc,
  output logic               o_pcwrite,
  output logic               o_branch,
  output logic               o_bne,
  output logic               o_illegal,
  output logic [STATE_W-1:0] o_state
);

  state_e     state_q;
  state_e     state_d;
  logic       illegal;
  ctrl_word_t ctrl;

  // NOTE: state flops use non-blocking assignments so every flop samples
  // values from before the edge, independent of process ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= FETCH;
    else          state_q <= state_d;
  end

  // Next-state logic. The opcode is only looked at in DECODE and MEMADR,
  // where the IR is stable because irwrite is low outside FETCH.
  always_comb begin
    state_d = state_q;
    illegal = 1'b0;
    case (state_q)
      FETCH:   if (i_mem_ready) state_d = DECODE;
      DECODE: begin
        case (i_opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
`ifdef MAIN_CTRL_BNE_EN
          OP_BNE:       state_d = BNEEX;
`endif
          default: begin
            state_d = FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      MEMADR:  state_d = (i_opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   if (i_mem_ready) state_d = MEMWB;
      MEMWB:   state_d = FETCH;
      MEMWR:   if (i_mem_ready) state_d = FETCH;
      RTYPEEX: state_d = RTYPEWB;
      RTYPEWB: state_d = FETCH;
      BEQEX:   state_d = FETCH;
      ADDIEX:  state_d = ADDIWB;
      ADDIWB:  state_d = FETCH;
      JEX:     state_d = FETCH;
`ifdef MAIN_CTRL_BNE_EN
      BNEEX:   state_d = FETCH;
`endif
      default: state_d = FETCH;
    endcase
  end

  main_control_fsm_ctrl_output_decoder u_ctrl_output_decoder (
    .i_state     (state_q),
    .i_mem_ready (i_mem_ready),
    .i_rst_n     (i_rst_n),
    .o_ctrl      (ctrl)
  );

  assign o_iord     = ctrl.iord;
  assign o_memwrite = ctrl.memwrite;
  assign o_irwrite  = ctrl.irwrite;
  assign o_regdst   = ctrl.regdst;
  assign o_memtoreg = ctrl.memtoreg;
  assign o_regwrite = ctrl.regwrite;
  assign o_alusrca  = ctrl.alusrca;
  assign o_alusrcb  = ctrl.alusrcb;
  assign o_aluop    = ctrl.aluop;
  assign o_pcsrc    = ctrl.pcsrc;
  assign o_pcwrite  = ctrl.pcwrite;
  assign o_branch   = ctrl.branch;
  assign o_bne      = ctrl.bne;
  // State is forced to FETCH during reset, so this is already 0 then.
  assign o_illegal  = illegal;
  assign o_state    = STATE_W'(state_q);

endmodule

// File: tb/tb_main_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_main_control_fsm
// Scoreboard bench for main_control_fsm. Each stimulus step drives the
// inputs for one cycle and queues the hand-written expected output set for
// that cycle; an independent monitor pops and compares on the falling edge.
// Builds with or without MAIN_CTRL_BNE_EN.
// -----------------------------------------------------------------------------
module tb_main_control_fsm;
  import main_control_fsm_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;

  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic       pcwrite, branch, bne, illegal;
  logic [3:0] state;

  always #5 clk = ~clk;

  main_control_fsm #(.STATE_W(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_opcode    (opcode),
    .i_mem_ready (mem_ready),
    .o_iord      (iord),
    .o_memwrite  (memwrite),
    .o_irwrite   (irwrite),
    .o_regdst    (regdst),
    .o_memtoreg  (memtoreg),
    .o_regwrite  (regwrite),
    .o_alusrca   (alusrca),
    .o_alusrcb   (alusrcb),
    .o_aluop     (aluop),
    .o_pcsrc     (pcsrc),
    .o_pcwrite   (pcwrite),
    .o_branch    (branch),
    .o_bne       (bne),
    .o_illegal   (illegal),
    .o_state     (state)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic       pcwrite, branch, bne, illegal;
  } obs_t;

  obs_t act;
  assign act = {state, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                alusrca, alusrcb, aluop, pcsrc, pcwrite, branch, bne, illegal};

  function automatic obs_t mk(
    input logic [3:0] st,
    input logic iord_e, memwrite_e, irwrite_e, regdst_e, memtoreg_e,
    input logic regwrite_e, alusrca_e,
    input logic [1:0] alusrcb_e, aluop_e, pcsrc_e,
    input logic pcwrite_e, branch_e, bne_e, illegal_e);
    return {st, iord_e, memwrite_e, irwrite_e, regdst_e, memtoreg_e, regwrite_e,
            alusrca_e, alusrcb_e, aluop_e, pcsrc_e, pcwrite_e, branch_e, bne_e,
            illegal_e};
  endfunction

  // Expected output sets, written from the state table.
  //                     st       io mw ir rd mr rw sa  srcb   aluop  pcsrc  pw br bn il
  obs_t e_fetch_rdy, e_fetch_wait, e_decode, e_decode_ill, e_memadr, e_memrd,
        e_memwb, e_memwr_rdy, e_memwr_wait, e_rtypeex, e_rtypewb, e_beqex,
        e_addiex, e_addiwb, e_jex, e_bneex;

  obs_t  exp_q[$];
  string name_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic check(input string nm, input obs_t got, input obs_t want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got state=%0d ctl=%h, expected state=%0d ctl=%h",
               nm, got.st, got, want.st, want);
    end
  endtask

  // Monitor: compare the oldest queued expectation every falling edge.
  obs_t  mon_e;
  string mon_n;
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_n = name_q.pop_front();
        check(mon_n, act, mon_e);
      end
    end
  end

  task automatic step(input string nm, input logic rst, input logic rdy,
                      input logic [5:0] op, input obs_t e);
    rst_n     = rst;
    mem_ready = rdy;
    opcode    = op;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    e_fetch_rdy  = mk(FETCH,   0,0,1,0,0,0,0, 2'b01,2'b00,2'b00, 1,0,0,0);
    e_fetch_wait = mk(FETCH,   0,0,0,0,0,0,0, 2'b01,2'b00,2'b00, 0,0,0,0);
    e_decode     = mk(DECODE,  0,0,0,0,0,0,0, 2'b11,2'b00,2'b00, 0,0,0,0);
    e_decode_ill = mk(DECODE,  0,0,0,0,0,0,0, 2'b11,2'b00,2'b00, 0,0,0,1);
    e_memadr     = mk(MEMADR,  0,0,0,0,0,0,1, 2'b10,2'b00,2'b00, 0,0,0,0);
    e_memrd      = mk(MEMRD,   1,0,0,0,0,0,0, 2'b00,2'b00,2'b00, 0,0,0,0);
    e_memwb      = mk(MEMWB,   0,0,0,0,1,1,0, 2'b00,2'b00,2'b00, 0,0,0,0);
    e_memwr_rdy  = mk(MEMWR,   1,1,0,0,0,0,0, 2'b00,2'b00,2'b00, 0,0,0,0);
    e_memwr_wait = mk(MEMWR,   1,0,0,0,0,0,0, 2'b00,2'b00,2'b00, 0,0,0,0);
    e_rtypeex    = mk(RTYPEEX, 0,0,0,0,0,0,1, 2'b00,2'b11,2'b00, 0,0,0,0);
    e_rtypewb    = mk(RTYPEWB, 0,0,0,1,0,1,0, 2'b00,2'b00,2'b00, 0,0,0,0);
    e_beqex      = mk(BEQEX,   0,0,0,0,0,0,1, 2'b00,2'b01,2'b01, 0,1,0,0);
    e_addiex     = mk(ADDIEX,  0,0,0,0,0,0,1, 2'b10,2'b00,2'b00, 0,0,0,0);
    e_addiwb     = mk(ADDIWB,  0,0,0,0,0,1,0, 2'b00,2'b00,2'b00, 0,0,0,0);
    e_jex        = mk(JEX,     0,0,0,0,0,0,0, 2'b00,2'b00,2'b10, 1,0,0,0);
    e_bneex      = mk(BNEEX,   0,0,0,0,0,0,1, 2'b00,2'b01,2'b01, 0,0,1,0);

    rst_n     = 1'b0;
    mem_ready = 1'b0;
    opcode    = 6'b0;
    @(posedge clk);
    #1;

    // Reset held with ready high: FETCH selects, every enable low.
    step("rst_hold",      0, 1, OP_LW,   e_fetch_wait);

    // LW, ready always high: 5 cycles.
    step("lw_fetch",      1, 1, OP_LW,   e_fetch_rdy);
    step("lw_decode",     1, 1, OP_LW,   e_decode);
    step("lw_memadr",     1, 1, OP_LW,   e_memadr);
    step("lw_memrd",      1, 1, OP_LW,   e_memrd);
    step("lw_memwb",      1, 1, OP_LW,   e_memwb);

    // SW with three not-ready cycles in MEMWR: single write strobe.
    step("sw_fetch",      1, 1, OP_SW,   e_fetch_rdy);
    step("sw_decode",     1, 1, OP_SW,   e_decode);
    step("sw_memadr",     1, 1, OP_SW,   e_memadr);
    step("sw_memwr_w1",   1, 0, OP_SW,   e_memwr_wait);
    step("sw_memwr_w2",   1, 0, OP_SW,   e_memwr_wait);
    step("sw_memwr_w3",   1, 0, OP_SW,   e_memwr_wait);
    step("sw_memwr_go",   1, 1, OP_SW,   e_memwr_rdy);

    // R-type.
    step("r_fetch",       1, 1, OP_RTYPE, e_fetch_rdy);
    step("r_decode",      1, 1, OP_RTYPE, e_decode);
    step("r_ex",          1, 1, OP_RTYPE, e_rtypeex);
    step("r_wb",          1, 1, OP_RTYPE, e_rtypewb);

    // BEQ.
    step("beq_fetch",     1, 1, OP_BEQ,  e_fetch_rdy);
    step("beq_decode",    1, 1, OP_BEQ,  e_decode);
    step("beq_ex",        1, 1, OP_BEQ,  e_beqex);

    // ADDI.
    step("addi_fetch",    1, 1, OP_ADDI, e_fetch_rdy);
    step("addi_decode",   1, 1, OP_ADDI, e_decode);
    step("addi_ex",       1, 1, OP_ADDI, e_addiex);
    step("addi_wb",       1, 1, OP_ADDI, e_addiwb);

    // J.
    step("j_fetch",       1, 1, OP_J,    e_fetch_rdy);
    step("j_decode",      1, 1, OP_J,    e_decode);
    step("j_ex",          1, 1, OP_J,    e_jex);

    // Unsupported opcode: pulse in DECODE, straight back to FETCH.
    step("ill_fetch",     1, 1, 6'b111111, e_fetch_rdy);
    step("ill_decode",    1, 1, 6'b111111, e_decode_ill);
    step("ill_refetch",   1, 0, 6'b111111, e_fetch_wait);

    // BNE: legal only with the option compiled in.
    step("bne_fetch",     1, 1, OP_BNE,  e_fetch_rdy);
`ifdef MAIN_CTRL_BNE_EN
    step("bne_decode",    1, 1, OP_BNE,  e_decode);
    step("bne_ex",        1, 1, OP_BNE,  e_bneex);
`else
    step("bne_decode_ill", 1, 1, OP_BNE, e_decode_ill);
`endif
    step("bne_after",     1, 0, OP_BNE,  e_fetch_wait);

    // LW with a MEMRD stall.
    step("lw2_fetch",     1, 1, OP_LW,   e_fetch_rdy);
    step("lw2_decode",    1, 1, OP_LW,   e_decode);
    step("lw2_memadr",    1, 0, OP_LW,   e_memadr);
    step("lw2_memrd_w",   1, 0, OP_LW,   e_memrd);
    step("lw2_memrd",     1, 1, OP_LW,   e_memrd);
    step("lw2_memwb",     1, 1, OP_LW,   e_memwb);

    // Reset asserted mid-MEMWR: instruction abandoned, no strobe.
    step("rs_fetch",      1, 1, OP_SW,   e_fetch_rdy);
    step("rs_decode",     1, 1, OP_SW,   e_decode);
    step("rs_memadr",     1, 1, OP_SW,   e_memadr);
    step("rs_memwr_w",    1, 0, OP_SW,   e_memwr_wait);
    step("rs_reset",      0, 1, OP_SW,   e_fetch_wait);
    step("rs_reset2",     0, 1, OP_SW,   e_fetch_wait);
    step("rs_release",    1, 0, OP_SW,   e_fetch_wait);
    step("rs_first_rdy",  1, 1, OP_RTYPE, e_fetch_rdy);
    step("rs_decode2",    1, 1, OP_RTYPE, e_decode);

    repeat (2) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
